// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serializer_stream block.
package serializer_pkg;

    // Shifter sequencing states; PARITY_S is only reachable when
    // SERIALIZER_STREAM_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        SHIFT_S  = 2'd1,
        PARITY_S = 2'd2
    } state_t;

    // Effective word length in bits (1..W).
    typedef int unsigned word_len_t;

    // A length field of 0 selects the full bus width.
    function automatic word_len_t eff_len(input int unsigned mod_val, input int unsigned width);
        return (mod_val == 0) ? width : mod_val;
    endfunction

endpackage

// File: rtl/serializer_stream_if.sv
// Parallel word input stream with valid/ready handshake.
interface serializer_stream_if #(
    parameter int unsigned DATA_BUS_WIDTH = 16,
    parameter int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
);
    logic [DATA_BUS_WIDTH-1:0] data_i;
    logic [DATA_MOD_WIDTH-1:0] data_mod_i;
    logic                      msb_first_i;
    logic                      data_val_i;
    logic                      data_rdy_o;

    // Word producer side.
    modport master (
        output data_i,
        output data_mod_i,
        output msb_first_i,
        output data_val_i,
        input  data_rdy_o
    );

    // Serializer side.
    modport slave (
        input  data_i,
        input  data_mod_i,
        input  msb_first_i,
        input  data_val_i,
        output data_rdy_o
    );
endinterface

// File: rtl/serializer_hold_buf.sv
// One-entry holding buffer: keeps a word (data, length, bit order) that
// arrived while the shifter was busy, until the shifter reloads it.
module serializer_hold_buf #(
    parameter int unsigned DATA_BUS_WIDTH = 16,
    parameter int unsigned LEN_WIDTH      = 5
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      i_load,
    input  logic                      i_unload,
    input  logic [DATA_BUS_WIDTH-1:0] i_data,
    input  logic [LEN_WIDTH-1:0]      i_len,
    input  logic                      i_msb_first,
    output logic                      o_valid,
    output logic [DATA_BUS_WIDTH-1:0] o_data,
    output logic [LEN_WIDTH-1:0]      o_len,
    output logic                      o_msb_first
);
    logic                      r_valid;
    logic [DATA_BUS_WIDTH-1:0] r_data;
    logic [LEN_WIDTH-1:0]      r_len;
    logic                      r_msb_first;

    // Capture on load, release on unload; load and unload never coincide.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_len       <= '0;
            r_msb_first <= 1'b0;
        end else if (i_load) begin
            r_valid     <= 1'b1;
            r_data      <= i_data;
            r_len       <= i_len;
            r_msb_first <= i_msb_first;
        end else if (i_unload) begin
            r_valid     <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_len       = r_len;
    assign o_msb_first = r_msb_first;
endmodule

// File: rtl/serializer_stream.sv
// Parallel-to-serial converter with per-word length and bit order, a
// valid/ready input and a one-word holding buffer for gapless streaming.
// Optional feature: define SERIALIZER_STREAM_PARITY_EN to append an even
// parity bit after each word's data bits.
module serializer_stream
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 16,
    parameter int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH),
    parameter int unsigned MIN_LEN        = 3
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    serializer_stream_if.slave   in_if,
    output logic                 ser_data_o,
    output logic                 ser_data_val_o,
    output logic                 ser_last_o,
    output logic                 drop_o,
    output logic                 busy_o
);
    localparam int unsigned LEN_WIDTH = DATA_MOD_WIDTH + 1;
    typedef logic [LEN_WIDTH-1:0] len_t;
    localparam len_t LEN_ONE = len_t'(1);

`ifdef SERIALIZER_STREAM_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    // Shifter state
    state_t                    r_state;
    logic [DATA_BUS_WIDTH-1:0] r_shift;
    len_t                      r_len;
    len_t                      r_cnt;
    logic                      r_msb;
    logic                      r_par;
    // Registered serial outputs
    logic                      r_ser_data;
    logic                      r_ser_val;
    logic                      r_ser_last;
    logic                      r_drop;

    // Input side
    logic                      w_rdy;
    logic                      w_accept;
    logic [31:0]               w_in_len_n;
    len_t                      w_in_len;
    logic                      w_in_drop;

    // Holding buffer
    logic                      w_hold_valid;
    logic [DATA_BUS_WIDTH-1:0] w_hold_data;
    len_t                      w_hold_len;
    logic                      w_hold_msb;
    logic                      w_hold_load;
    logic                      w_hold_unload;

    // Shifter control
    logic                      w_last_data;
    logic                      w_free;
    logic [DATA_BUS_WIDTH-1:0] w_shifted;
    logic                      w_adv_bit;
    logic                      w_load;
    logic [DATA_BUS_WIDTH-1:0] w_ld_data;
    len_t                      w_ld_len;
    logic                      w_ld_msb;
    logic                      w_ld_first;

    state_t                    w_state_nx;
    logic [DATA_BUS_WIDTH-1:0] w_shift_nx;
    len_t                      w_len_nx;
    len_t                      w_cnt_nx;
    logic                      w_msb_nx;
    logic                      w_par_nx;
    logic                      w_ser_data_nx;
    logic                      w_ser_val_nx;
    logic                      w_ser_last_nx;

    assign w_rdy           = !w_hold_valid;
    assign in_if.data_rdy_o = w_rdy;
    assign w_accept        = in_if.data_val_i && w_rdy;
    assign w_in_len_n      = eff_len(32'(in_if.data_mod_i), DATA_BUS_WIDTH);
    assign w_in_len        = len_t'(w_in_len_n);
    assign w_in_drop       = (w_in_len_n < MIN_LEN);

    // The shifter can take a new word when idle or during the final cycle
    // of the current word (parity cycle when parity is enabled).
    assign w_last_data = (r_state == SHIFT_S) && (r_cnt == r_len - LEN_ONE);
    assign w_free      = (r_state == IDLE_S) || (r_state == PARITY_S) ||
                         (!PARITY_EN && w_last_data);

    assign w_hold_unload = w_free && w_hold_valid;
    assign w_hold_load   = w_accept && !w_in_drop && !w_free;

    // Buffered word has priority; it can only exist while the shifter is busy.
    assign w_load     = w_free && (w_hold_valid || (w_accept && !w_in_drop));
    assign w_ld_data  = w_hold_valid ? w_hold_data : in_if.data_i;
    assign w_ld_len   = w_hold_valid ? w_hold_len  : w_in_len;
    assign w_ld_msb   = w_hold_valid ? w_hold_msb  : in_if.msb_first_i;
    assign w_ld_first = w_ld_msb ? w_ld_data[DATA_BUS_WIDTH-1] : w_ld_data[0];

    assign w_shifted = r_msb ? {r_shift[DATA_BUS_WIDTH-2:0], 1'b0}
                             : {1'b0, r_shift[DATA_BUS_WIDTH-1:1]};
    assign w_adv_bit = r_msb ? w_shifted[DATA_BUS_WIDTH-1] : w_shifted[0];

    serializer_hold_buf #(
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
        .LEN_WIDTH      (LEN_WIDTH)
    ) u_hold_buf (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .i_load      (w_hold_load),
        .i_unload    (w_hold_unload),
        .i_data      (in_if.data_i),
        .i_len       (w_in_len),
        .i_msb_first (in_if.msb_first_i),
        .o_valid     (w_hold_valid),
        .o_data      (w_hold_data),
        .o_len       (w_hold_len),
        .o_msb_first (w_hold_msb)
    );

    // Next-state and next serial output values; a load overrides the
    // end-of-word transition so back-to-back words have no gap.
    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_len_nx      = r_len;
        w_cnt_nx      = r_cnt;
        w_msb_nx      = r_msb;
        w_par_nx      = r_par;
        w_ser_data_nx = 1'b0;
        w_ser_val_nx  = 1'b0;
        w_ser_last_nx = 1'b0;

        case (r_state)
            SHIFT_S: begin
                if (!w_last_data) begin
                    w_shift_nx    = w_shifted;
                    w_cnt_nx      = r_cnt + LEN_ONE;
                    w_par_nx      = r_par ^ w_adv_bit;
                    w_ser_data_nx = w_adv_bit;
                    w_ser_val_nx  = 1'b1;
                    w_ser_last_nx = !PARITY_EN && ((r_cnt + LEN_ONE) == (r_len - LEN_ONE));
                end else if (PARITY_EN) begin
                    w_state_nx    = PARITY_S;
                    w_ser_data_nx = r_par;
                    w_ser_val_nx  = 1'b1;
                    w_ser_last_nx = 1'b1;
                end else begin
                    w_state_nx = IDLE_S;
                end
            end
            PARITY_S: w_state_nx = IDLE_S;
            default:  w_state_nx = IDLE_S;
        endcase

        if (w_load) begin
            w_state_nx    = SHIFT_S;
            w_shift_nx    = w_ld_data;
            w_len_nx      = w_ld_len;
            w_cnt_nx      = '0;
            w_msb_nx      = w_ld_msb;
            w_par_nx      = w_ld_first;
            w_ser_data_nx = w_ld_first;
            w_ser_val_nx  = 1'b1;
            w_ser_last_nx = !PARITY_EN && (w_ld_len == LEN_ONE);
        end
    end

    // State and registered serial outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= IDLE_S;
            r_shift    <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_msb      <= 1'b0;
            r_par      <= 1'b0;
            r_ser_data <= 1'b0;
            r_ser_val  <= 1'b0;
            r_ser_last <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_len      <= w_len_nx;
            r_cnt      <= w_cnt_nx;
            r_msb      <= w_msb_nx;
            r_par      <= w_par_nx;
            r_ser_data <= w_ser_data_nx;
            r_ser_val  <= w_ser_val_nx;
            r_ser_last <= w_ser_last_nx;
            r_drop     <= w_accept && w_in_drop;
        end
    end

    assign ser_data_o     = r_ser_data;
    assign ser_data_val_o = r_ser_val;
    assign ser_last_o     = r_ser_last;
    assign drop_o         = r_drop;
    assign busy_o         = (r_state != IDLE_S) || w_hold_valid;
endmodule

// File: tb/tb_serializer_stream.sv
// Bench for serializer_stream: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a bit-queue model.
module tb_serializer_stream;
    localparam int unsigned W    = 16;
    localparam int unsigned MW   = 4;
    localparam int unsigned MINL = 3;

`ifdef SERIALIZER_STREAM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic arst;
    logic ser_data, ser_val, ser_last, drop, busy;

    always #5 clk = ~clk;

    serializer_stream_if #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW)) sif ();

    serializer_stream #(
        .DATA_BUS_WIDTH (W),
        .DATA_MOD_WIDTH (MW),
        .MIN_LEN        (MINL)
    ) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .in_if          (sif.slave),
        .ser_data_o     (ser_data),
        .ser_data_val_o (ser_val),
        .ser_last_o     (ser_last),
        .drop_o         (drop),
        .busy_o         (busy)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        logic        msb;
        logic [15:0] exp_bits;  // send order, first bit at [15]
        int          exp_n;
        logic        exp_drop;
    } vec_t;

    vec_t vecs[7];

    // Drive one word, then follow its serial output to completion.
    task automatic run_vec(input vec_t v);
        int   n;
        int   tot;
        int   waitc;
        logic eb;
        @(negedge clk);
        sif.data_i      = v.data;
        sif.data_mod_i  = v.mod;
        sif.msb_first_i = v.msb;
        sif.data_val_i  = 1'b1;
        waitc = 0;
        while (!sif.data_rdy_o && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        check("vec_accept", 32'(sif.data_rdy_o), 32'd1);
        @(negedge clk);
        sif.data_val_i = 1'b0;
        check("vec_drop", 32'(drop), 32'(v.exp_drop));
        tot = v.exp_n + ((PAR != 0 && !v.exp_drop) ? 1 : 0);
        check("vec_first_val", 32'(ser_val), 32'(tot != 0));
        n = 0;
        while (ser_val && n < 40) begin
            if (n < v.exp_n) eb = v.exp_bits[15 - n];
            else             eb = ^v.exp_bits;
            check("vec_bit", 32'(ser_data), 32'(eb));
            check("vec_last", 32'(ser_last), 32'(n == tot - 1));
            n++;
            @(negedge clk);
        end
        if (n == 0) @(negedge clk);
        check("vec_len", 32'(n), 32'(tot));
        check("vec_busy_end", 32'(busy), 32'd0);
        check("vec_drop_end", 32'(drop), 32'd0);
    endtask

    // Reference model: a queue of {bit, last} expected on the serial line.
    logic [1:0] expq[$];
    logic       exp_drop_next;

    task automatic model_accept(input logic [15:0] d, input logic [3:0] m, input logic msb);
        int   len;
        logic b;
        logic p;
        len = (m == 0) ? 16 : int'(m);
        if (len < int'(MINL)) begin
            exp_drop_next = 1'b1;
        end else begin
            p = 1'b0;
            for (int i = 0; i < len; i++) begin
                b = msb ? d[15 - i] : d[i];
                p = p ^ b;
                expq.push_back({b, logic'(PAR == 0 && i == len - 1)});
            end
            if (PAR != 0) expq.push_back({p, 1'b1});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        logic [15:0] words[3];
        int          k;
        int          idx;
        int          per;
        logic        started, ended, extra, seen_low;
        logic        eb;
        logic [1:0]  e;
        logic [15:0] rd;
        logic [3:0]  rm;
        logic        rmsb, rval;

        vecs[0] = '{16'hA5C3, 4'd0, 1'b1, 16'hA5C3, 16, 1'b0};
        vecs[1] = '{16'hA5C3, 4'd4, 1'b0, 16'hC000,  4, 1'b0};
        vecs[2] = '{16'hA5C3, 4'd2, 1'b1, 16'h0000,  0, 1'b1};
        vecs[3] = '{16'hA5C3, 4'd3, 1'b1, 16'hA000,  3, 1'b0};
        vecs[4] = '{16'h0001, 4'd0, 1'b0, 16'h8000, 16, 1'b0};
        vecs[5] = '{16'h8000, 4'd1, 1'b1, 16'h0000,  0, 1'b1};
        vecs[6] = '{16'hF0F0, 4'd8, 1'b0, 16'h0F00,  8, 1'b0};

        sif.data_i      = '0;
        sif.data_mod_i  = '0;
        sif.msb_first_i = 1'b0;
        sif.data_val_i  = 1'b0;
        arst            = 1'b1;

        // Reset state
        #1;
        check("rst_ser_data", 32'(ser_data), 32'd0);
        check("rst_ser_val",  32'(ser_val),  32'd0);
        check("rst_ser_last", 32'(ser_last), 32'd0);
        check("rst_drop",     32'(drop),     32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("rst_rdy", 32'(sif.data_rdy_o), 32'd1);

        // Vector table
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Back-to-back words with valid held high
        words[0] = 16'h1234;
        words[1] = 16'hFFFF;
        words[2] = 16'h00F0;
        per      = 16 + PAR;
        k        = 0;
        idx      = 0;
        started  = 1'b0;
        ended    = 1'b0;
        extra    = 1'b0;
        seen_low = 1'b0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (ser_val) begin
                if (!ended && idx < 3 * per) begin
                    started = 1'b1;
                    rd = words[idx / per];
                    if ((idx % per) < 16) eb = rd[15 - (idx % per)];
                    else                  eb = ^rd;
                    check("b2b_bit", 32'(ser_data), 32'(eb));
                    check("b2b_last", 32'(ser_last), 32'((idx % per) == per - 1));
                    idx++;
                end else begin
                    extra = 1'b1;
                end
            end else if (started) begin
                ended = 1'b1;
            end
            if (k > 0 && k < 3 && !sif.data_rdy_o) seen_low = 1'b1;
            if (k < 3) begin
                sif.data_i      = words[k];
                sif.data_mod_i  = '0;
                sif.msb_first_i = 1'b1;
                sif.data_val_i  = 1'b1;
                if (sif.data_rdy_o) k++;
            end else begin
                sif.data_val_i = 1'b0;
            end
        end
        check("b2b_count",  32'(idx), 32'(3 * per));
        check("b2b_contig", 32'(extra), 32'd0);
        check("b2b_rdy_low", 32'(seen_low), 32'd1);
        check("b2b_busy_end", 32'(busy), 32'd0);

        // Reset in the middle of a word
        @(negedge clk);
        sif.data_i      = 16'hA5C3;
        sif.data_mod_i  = '0;
        sif.msb_first_i = 1'b1;
        sif.data_val_i  = 1'b1;
        @(negedge clk);
        sif.data_val_i  = 1'b0;
        check("mid_started", 32'(ser_val), 32'd1);
        for (int i = 0; i < 6; i++) @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("mid_ser_val",  32'(ser_val),  32'd0);
        check("mid_ser_data", 32'(ser_data), 32'd0);
        check("mid_ser_last", 32'(ser_last), 32'd0);
        check("mid_busy",     32'(busy),     32'd0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("mid_rdy", 32'(sif.data_rdy_o), 32'd1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("mid_no_resume", 32'(ser_val), 32'd0);
        run_vec(vecs[0]);

        // Randomized traffic against the queue model
        exp_drop_next = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            check("rnd_drop", 32'(drop), 32'(exp_drop_next));
            exp_drop_next = 1'b0;
            if (ser_val) begin
                if (expq.size() == 0) begin
                    check("rnd_extra_bit", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("rnd_bit",  32'(ser_data), 32'(e[1]));
                    check("rnd_last", 32'(ser_last), 32'(e[0]));
                end
            end
            if (c < 1300) begin
                rval = ($urandom_range(0, 3) != 0);
                rd   = 16'($urandom);
                rm   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3))
                                                   : 4'($urandom_range(0, 15));
                rmsb = 1'($urandom_range(0, 1));
                sif.data_i      = rd;
                sif.data_mod_i  = rm;
                sif.msb_first_i = rmsb;
                sif.data_val_i  = rval;
                if (rval && sif.data_rdy_o) model_accept(rd, rm, rmsb);
            end else begin
                sif.data_val_i = 1'b0;
            end
        end
        check("rnd_queue_empty", 32'(expq.size()), 32'd0);
        check("rnd_busy_end", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
